// File: rtl/mbist_pkg.sv
// Shared MBIST/MBISR definitions: default geometry and fail-logger state encoding.
package mbist_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    // Fail-logger capture states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOGGING  = 2'd1,
        ST_COMPLETE = 2'd2
    } log_state_e;

endpackage

// File: rtl/fail_log_cam.sv
// Fail-address storage with per-entry valid bits and a parallel match vector.
module fail_log_cam
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_idx,
    input  logic [ADDR_WIDTH-1:0] wr_data,
    input  logic                  pop_en,
    input  logic [PTR_W-1:0]      pop_idx,
    input  logic [ADDR_WIDTH-1:0] cmp_addr,
    output logic [ADDR_WIDTH-1:0] rd_entry_c,
    output logic [DEPTH-1:0]      match_vec_c
);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // Entry storage; liveness is tracked by valid_q so no reset is needed here
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Valid bits: pop clears, push sets; push wins when both hit the same slot
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else begin
            if (pop_en) begin
                valid_q[pop_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Parallel compare against every live entry, using pre-edge contents
    always_comb begin
        match_vec_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match_vec_c[i] = valid_q[i] && (mem_q[i] == cmp_addr);
        end
    end

    // Read port at the head of the FIFO
    always_comb begin
        rd_entry_c = mem_q[pop_idx];
    end

endmodule

// File: rtl/mbist_fail_logger.sv
// Captures unique MBIST failing addresses into a FIFO log for repair loading.
module mbist_fail_logger
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       fail_valid,
    input  logic [ADDR_WIDTH-1:0]      fail_addr,
    input  logic                       bist_done,
    input  logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       log_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    log_state_e            state_q;
    log_state_e            state_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_d;
    logic [DEPTH-1:0]      cam_match_c;
    logic [ADDR_WIDTH-1:0] cam_rd_entry_c;
    logic                  dup_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  lose_c;
    logic                  done_set_c;
    logic                  cam_clr_c;

    assign dup_c     = |cam_match_c;
    assign cam_clr_c = !rst || start;

    fail_log_cam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_cam (
        .clk         (clk),
        .clr         (cam_clr_c),
        .wr_en       (push_c),
        .wr_idx      (wr_ptr_q),
        .wr_data     (fail_addr),
        .pop_en      (pop_c),
        .pop_idx     (rd_ptr_q),
        .cmp_addr    (fail_addr),
        .rd_entry_c  (cam_rd_entry_c),
        .match_vec_c (cam_match_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle push/pop/overflow decisions; start overrides all
    always_comb begin
        state_d    = state_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        lose_c     = 1'b0;
        done_set_c = 1'b0;
        if (start) begin
            state_d = ST_LOGGING;
        end else begin
            pop_c = rd_en && !empty;
            case (state_q)
                ST_IDLE: begin
                end
                ST_LOGGING: begin
                    if (fail_valid && !dup_c) begin
                        if (!full || pop_c) begin
                            push_c = 1'b1;
                        end else begin
                            lose_c = 1'b1;
                        end
                    end
                    if (bist_done) begin
                        state_d    = ST_COMPLETE;
                        done_set_c = 1'b1;
                    end
                end
                ST_COMPLETE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Occupancy after this edge
    always_comb begin
        count_d = count;
        case ({push_c, pop_c})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Pointers, occupancy flags, read port and sticky status
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            log_done <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            log_done <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                rd_data  <= cam_rd_entry_c;
            end
            rd_valid <= pop_c;
            count    <= count_d;
            empty    <= (count_d == '0);
            full     <= (count_d == CNT_W'(DEPTH));
            if (lose_c) begin
                overflow <= 1'b1;
            end
            if (done_set_c) begin
                log_done <= 1'b1;
            end
        end
    end

endmodule
